// File: rtl/fetch_queue.sv
// Decoupled instruction-fetch front end: PC generator, credit-limited memory request port
// and a DEPTH-entry prefetch queue feeding decode, with stale-response discard on redirect.
module fetch_queue #(
    parameter int              PC_W     = 32,
    parameter int              INS_W    = 32,
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     redirect,
    input  logic [PC_W-1:0]          redirect_pc,
    output logic                     imem_req_valid,
    input  logic                     imem_req_ready,
    output logic [PC_W-1:0]          imem_req_addr,
    input  logic                     imem_resp_valid,
    input  logic [INS_W-1:0]         imem_resp_insn,
    output logic                     id_valid,
    input  logic                     id_ready,
    output logic [PC_W-1:0]          id_pc,
    output logic [INS_W-1:0]         id_insn,
    output logic [$clog2(DEPTH):0]   fq_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

    logic [PC_W-1:0]  r_fetch_pc;
    logic [PC_W-1:0]  r_resp_pc;
    logic [PC_W-1:0]  r_q_pc   [DEPTH];
    logic [INS_W-1:0] r_q_insn [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    r_outstanding;
    logic [CW-1:0]    r_drop;

    logic             w_credit;
    logic             w_req_valid;
    logic             w_hs;
    logic             w_resp_acc;
    logic             w_resp_drop;
    logic             w_enq;
    logic             w_id_valid;
    logic             w_deq;
    logic [CW-1:0]    w_out_next;

    // Queued plus in-flight never exceeds DEPTH, so an accepted response always has a slot.
    assign w_credit    = ({1'b0, r_count} + {1'b0, r_outstanding}) < DEPTH_L;
    assign w_req_valid = !reset && !redirect && w_credit;
    assign w_hs        = w_req_valid && imem_req_ready;
    assign w_resp_acc  = imem_resp_valid && (r_outstanding != '0);
    assign w_resp_drop = w_resp_acc && (r_drop != '0);
    assign w_enq       = w_resp_acc && !w_resp_drop && !redirect && !reset;
    assign w_id_valid  = !reset && (r_count != '0);
    assign w_deq       = w_id_valid && id_ready;
    assign w_out_next  = r_outstanding + CW'(w_hs) - CW'(w_resp_acc);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_drop        <= '0;
        end else begin
            r_outstanding <= w_out_next;
            if (redirect) begin
                // Everything still in flight after this cycle belongs to the old path.
                r_fetch_pc <= redirect_pc;
                r_resp_pc  <= redirect_pc;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_count    <= '0;
                r_drop     <= w_out_next;
            end else begin
                if (w_hs) begin
                    r_fetch_pc <= r_fetch_pc + PC_W'(4);
                end
                if (w_resp_drop) begin
                    r_drop <= r_drop - 1'b1;
                end
                if (w_enq) begin
                    r_resp_pc <= r_resp_pc + PC_W'(4);
                    r_wr_ptr  <= r_wr_ptr + 1'b1;
                end
                if (w_deq) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                r_count <= r_count + CW'(w_enq) - CW'(w_deq);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_q_pc[i]   <= '0;
                r_q_insn[i] <= '0;
            end
        end else if (w_enq) begin
            r_q_pc[r_wr_ptr]   <= r_resp_pc;
            r_q_insn[r_wr_ptr] <= imem_resp_insn;
        end
    end

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_fetch_pc;
    assign id_valid       = w_id_valid;
    assign id_pc          = r_q_pc[r_rd_ptr];
    assign id_insn        = r_q_insn[r_rd_ptr];
    assign fq_count       = r_count;

endmodule
